decoder_2to4_hold: RTL and testbench
====================================

DECODER_2TO4_HOLD -- requirements
Module: decoder_2to4_hold

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, 4, number of cycles a decoded one-hot output stays asserted (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: A  input  1  code MSB.
REQ-005 SHALL have port: B  input  1  code LSB.
REQ-006 SHALL have port: in_valid  input  1  code on A,B is presented this cycle.
REQ-007 SHALL have port: in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have ports: Q0, Q1, Q2, Q3  output  1 each  registered one-hot decoded lines.
REQ-009 SHALL have port: out_valid  output  1  one decoded line is currently asserted.
REQ-010 SHALL have port, only when DECODER_STAT_EN is defined: dec_count  output  8  accepted-code counter.

Function
REQ-011 SHALL decode {A,B}: 00->Q0, 01->Q1, 10->Q2, 11->Q3, the inverse of the team's 4-to-2 encoder mapping.
REQ-012 SHALL implement a two-state FSM: IDLE, HOLD.
REQ-013 SHALL drive in_ready combinationally as (state == IDLE).
REQ-014 SHALL accept a code on a rising edge where state is IDLE and in_valid=1; accepted {A,B} is latched.
REQ-015 SHALL, on acceptance, set the matching Q line and out_valid on that same edge (latency 1 cycle from in_valid sample to output), enter HOLD, and load an 8-bit hold counter with HOLD_CYCLES-1.
REQ-016 SHALL, in HOLD, decrement the hold counter each edge while counter != 0, keeping Q and out_valid stable.
REQ-017 SHALL, on the edge where state is HOLD and counter == 0, clear Q0..Q3 to 0, clear out_valid, and return to IDLE; the output is therefore high for exactly HOLD_CYCLES cycles.
REQ-018 SHALL ignore in_valid while in HOLD; codes are neither queued nor latched.
REQ-019 SHALL guarantee at most one Q line is high at any time; all Q lines are 0 whenever out_valid=0.
REQ-020 SHALL permit the next acceptance no earlier than the first cycle in IDLE after clearing (minimum spacing HOLD_CYCLES+1 cycles between accepts).
REQ-021 SHALL, with HOLD_CYCLES=1, assert the Q line for one cycle and enter HOLD with counter 0.
REQ-022 SHALL ignore changes on A,B while in HOLD; Q reflects the latched code only.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, set state=IDLE, Q0..Q3=0, out_valid=0, hold counter=0, dec_count=0.
REQ-024 SHALL give reset priority over in_valid in the same cycle; no code is accepted on a reset edge.
REQ-025 SHALL abort an in-progress HOLD on reset; outputs clear on that edge, with no residual pulse afterward.

Configuration
REQ-026 SHALL, when macro DECODER_STAT_EN is defined, include dec_count: increments by 1 on every accepted code and saturates at 255.
REQ-027 SHALL, when DECODER_STAT_EN is undefined, omit the dec_count port and counter logic entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover: reset 2 cycles, then {A,B}=10, in_valid 1 cycle, HOLD_CYCLES=4 -> Q2=1 and out_valid=1 for exactly 4 cycles starting 1 cycle after sample; Q0,Q1,Q3 stay 0; in_ready=0 during those 4 cycles.
REQ-029 SHALL cover: all four codes 00,01,10,11 applied in turn, each at first in_ready=1 -> Q0,Q1,Q2,Q3 pulse in order, one-hot, each 4 cycles, gaps of 1 cycle.
REQ-030 SHALL cover: in_valid held 1 with {A,B}=11 changing to 00 during HOLD -> Q3 held full 4 cycles; 00 accepted only at next IDLE cycle, yielding Q0.
REQ-031 SHALL cover: reset asserted 2 cycles into a HOLD of code 01 -> Q1 and out_valid 0 after that edge; in_ready=1 the following cycle.
REQ-032 SHALL cover: HOLD_CYCLES=1, back-to-back in_valid with codes 00,11 -> Q0 high 1 cycle, 1 idle cycle, Q3 high 1 cycle.
REQ-033 SHALL cover, with DECODER_STAT_EN defined: 300 accepted codes -> dec_count reads 255 and holds; after reset reads 0.

Source files
------------

// File: rtl/decoder_2to4_hold.sv
// decoder_2to4_hold
// Decodes a 2-bit code {A,B} into one of four registered one-hot lines and
// holds the selected line high for HOLD_CYCLES clock cycles. New codes are
// accepted only while idle; anything presented during a hold is dropped.
//
// Optional build macro: DECODER_STAT_EN
//   When defined, adds the dec_count output, a saturating 8-bit count of
//   accepted codes. When undefined, the port and its counter are absent.
//
// FSM states:
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no line asserted; in_ready=1; a valid code is accepted here
//   HOLD  | one line asserted; hold counter runs down to 0, then clears
module decoder_2to4_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       out_valid
`ifdef DECODER_STAT_EN
    ,
    output logic [7:0] dec_count
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Counter reload value: the accept edge itself is the first held cycle.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_code;
    logic [3:0] r_q;
    logic       r_out_valid;

    logic [1:0] w_code;
    logic       w_accept;
    logic       w_hold_done;
    logic [3:0] w_onehot;

    assign w_code      = {A, B};
    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_hold_done = (r_state == S_HOLD) && (r_hold_cnt == 8'd0);

    // One-hot decode of the incoming code; only sampled on an accept edge.
    always_comb begin
        w_onehot = 4'b0000;
        case (w_code)
            2'b00:   w_onehot = 4'b0001;
            2'b01:   w_onehot = 4'b0010;
            2'b10:   w_onehot = 4'b0100;
            default: w_onehot = 4'b1000;
        endcase
    end

    // State register; reset wins over any pending accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE->HOLD on accept, HOLD->IDLE when counter expires.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Hold counter: load on accept, count down in HOLD, stop at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 8'd0;
        end else if (w_accept) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if ((r_state == S_HOLD) && (r_hold_cnt != 8'd0)) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
        end
    end

    // Latched code and registered outputs; A,B are ignored outside the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code      <= 2'b00;
            r_q         <= 4'b0000;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_code      <= w_code;
            r_q         <= w_onehot;
            r_out_valid <= 1'b1;
        end else if (w_hold_done) begin
            r_q         <= 4'b0000;
            r_out_valid <= 1'b0;
        end
    end

    // Output logic: ready only while idle, Q lines straight from the register.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        Q0        = r_q[0];
        Q1        = r_q[1];
        Q2        = r_q[2];
        Q3        = r_q[3];
        out_valid = r_out_valid;
    end

`ifdef DECODER_STAT_EN
    logic [7:0] r_dec_count;

    // Accepted-code counter, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_count <= 8'd0;
        end else if (w_accept && (r_dec_count != 8'hFF)) begin
            r_dec_count <= r_dec_count + 8'd1;
        end
    end

    assign dec_count = r_dec_count;
`endif

    // r_code documents the accepted code for debug visibility; fold it into
    // a reduction so it is not flagged as an unused register.
    logic w_code_unused;
    assign w_code_unused = ^r_code;

endmodule

// File: tb/tb_decoder_2to4_hold.sv
module tb_decoder_2to4_hold;

    logic clk = 1'b0;
    logic reset;

    logic A, B, in_valid, in_ready;
    logic Q0, Q1, Q2, Q3, out_valid;

    logic A1, B1, in_valid1, in_ready1;
    logic P0, P1, P2, P3, out_valid1;

`ifdef DECODER_STAT_EN
    logic [7:0] dec_count;
    logic [7:0] dec_count1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_2to4_hold #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .in_valid(in_valid),
        .in_ready(in_ready), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
        .out_valid(out_valid)
`ifdef DECODER_STAT_EN
        , .dec_count(dec_count)
`endif
    );

    decoder_2to4_hold #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .A(A1), .B(B1), .in_valid(in_valid1),
        .in_ready(in_ready1), .Q0(P0), .Q1(P1), .Q2(P2), .Q3(P3),
        .out_valid(out_valid1)
`ifdef DECODER_STAT_EN
        , .dec_count(dec_count1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // exp_q packed as {Q3,Q2,Q1,Q0}
    task automatic chk4(input string tag, input logic [3:0] exp_q, input logic exp_ov, input logic exp_rdy);
        chk({tag, ".q"},   {4'b0, Q3, Q2, Q1, Q0}, {4'b0, exp_q});
        chk({tag, ".ov"},  {7'b0, out_valid},      {7'b0, exp_ov});
        chk({tag, ".rdy"}, {7'b0, in_ready},       {7'b0, exp_rdy});
    endtask

    task automatic chk1(input string tag, input logic [3:0] exp_q, input logic exp_ov, input logic exp_rdy);
        chk({tag, ".q"},   {4'b0, P3, P2, P1, P0}, {4'b0, exp_q});
        chk({tag, ".ov"},  {7'b0, out_valid1},     {7'b0, exp_ov});
        chk({tag, ".rdy"}, {7'b0, in_ready1},      {7'b0, exp_rdy});
    endtask

    initial begin
        reset = 1'b1; A = 1'b0; B = 1'b0; in_valid = 1'b0;
        A1 = 1'b0; B1 = 1'b0; in_valid1 = 1'b0;

        // Reset for two cycles
        tick(); tick();
        reset = 1'b0;
        chk4("reset", 4'b0000, 1'b0, 1'b1);
        chk1("reset1", 4'b0000, 1'b0, 1'b1);
`ifdef DECODER_STAT_EN
        chk("reset.cnt", dec_count, 8'd0);
`endif

        // Code 10 for one cycle -> Q2 for exactly 4 cycles
        A = 1'b1; B = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk4("c10.h1", 4'b0100, 1'b1, 1'b0);
        tick(); chk4("c10.h2", 4'b0100, 1'b1, 1'b0);
        tick(); chk4("c10.h3", 4'b0100, 1'b1, 1'b0);
        tick(); chk4("c10.h4", 4'b0100, 1'b1, 1'b0);
        tick(); chk4("c10.end", 4'b0000, 1'b0, 1'b1);
        tick(); chk4("c10.idle", 4'b0000, 1'b0, 1'b1);

        // All four codes in turn, each at the first in_ready cycle
        A = 1'b0; B = 1'b0; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk4("seq0.h1", 4'b0001, 1'b1, 1'b0);
        tick(); tick(); tick(); chk4("seq0.h4", 4'b0001, 1'b1, 1'b0);
        tick(); chk4("seq0.gap", 4'b0000, 1'b0, 1'b1);
        A = 1'b0; B = 1'b1; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk4("seq1.h1", 4'b0010, 1'b1, 1'b0);
        tick(); tick(); tick(); chk4("seq1.h4", 4'b0010, 1'b1, 1'b0);
        tick(); chk4("seq1.gap", 4'b0000, 1'b0, 1'b1);
        A = 1'b1; B = 1'b0; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk4("seq2.h1", 4'b0100, 1'b1, 1'b0);
        tick(); tick(); tick(); chk4("seq2.h4", 4'b0100, 1'b1, 1'b0);
        tick(); chk4("seq2.gap", 4'b0000, 1'b0, 1'b1);
        A = 1'b1; B = 1'b1; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk4("seq3.h1", 4'b1000, 1'b1, 1'b0);
        tick(); tick(); tick(); chk4("seq3.h4", 4'b1000, 1'b1, 1'b0);
        tick(); chk4("seq3.gap", 4'b0000, 1'b0, 1'b1);

        // in_valid held; code 11 changes to 00 during HOLD
        A = 1'b1; B = 1'b1; in_valid = 1'b1;
        tick();
        chk4("chg.h1", 4'b1000, 1'b1, 1'b0);
        A = 1'b0; B = 1'b0;
        tick(); chk4("chg.h2", 4'b1000, 1'b1, 1'b0);
        tick(); chk4("chg.h3", 4'b1000, 1'b1, 1'b0);
        tick(); chk4("chg.h4", 4'b1000, 1'b1, 1'b0);
        tick(); chk4("chg.idle", 4'b0000, 1'b0, 1'b1);
        tick(); chk4("chg.q0", 4'b0001, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick(); tick(); tick(); chk4("chg.q0h4", 4'b0001, 1'b1, 1'b0);
        tick(); chk4("chg.end", 4'b0000, 1'b0, 1'b1);

        // Reset aborts a HOLD of code 01 two cycles in
        A = 1'b0; B = 1'b1; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk4("abort.h1", 4'b0010, 1'b1, 1'b0);
        tick(); chk4("abort.h2", 4'b0010, 1'b1, 1'b0);
        reset = 1'b1; in_valid = 1'b1; A = 1'b1; B = 1'b1;
        tick(); chk4("abort.rst", 4'b0000, 1'b0, 1'b1);
        tick(); chk4("abort.rstprio", 4'b0000, 1'b0, 1'b1);
        reset = 1'b0; in_valid = 1'b0;
        tick(); chk4("abort.after1", 4'b0000, 1'b0, 1'b1);
        tick(); tick(); chk4("abort.after3", 4'b0000, 1'b0, 1'b1);

        // HOLD_CYCLES=1, back-to-back codes 00 then 11
        A1 = 1'b0; B1 = 1'b0; in_valid1 = 1'b1;
        tick(); chk1("h1.q0", 4'b0001, 1'b1, 1'b0);
        A1 = 1'b1; B1 = 1'b1;
        tick(); chk1("h1.gap", 4'b0000, 1'b0, 1'b1);
        tick(); chk1("h1.q3", 4'b1000, 1'b1, 1'b0);
        in_valid1 = 1'b0;
        tick(); chk1("h1.end", 4'b0000, 1'b0, 1'b1);
        tick(); chk1("h1.idle", 4'b0000, 1'b0, 1'b1);

`ifdef DECODER_STAT_EN
        // Saturation of the accepted-code counter
        reset = 1'b1; tick(); reset = 1'b0;
        chk("stat.rst0", dec_count, 8'd0);
        for (int i = 0; i < 300; i++) begin
            A = i[1]; B = i[0]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i == 9) chk("stat.10", dec_count, 8'd10);
            if (i == 254) chk("stat.255", dec_count, 8'd255);
            tick(); tick(); tick(); tick();
        end
        chk("stat.sat", dec_count, 8'd255);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("stat.rst", dec_count, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
